intr_controller: RTL and testbench

INTR_CONTROLLER -- requirements
Module: intr_controller

---
 rtl/intc_pkg.sv | 21 ++
 rtl/intc_prio_sel.sv | 35 +++
 rtl/intr_controller.sv | 146 ++++++++++++++
 tb/tb_intr_controller.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/intc_pkg.sv
// Shared constants and types for the interrupt controller.
//   INTC_NUM_SRC       number of interrupt sources (8)
//   INTC_ID_W          width of a source index
//   INTC_OFS_*         register offsets on the 12-bit Addr bus
//   intc_state_e       controller FSM state encoding
package intc_pkg;

  localparam int INTC_NUM_SRC = 8;
  localparam int INTC_ID_W    = $clog2(INTC_NUM_SRC);

  localparam logic [11:0] INTC_OFS_PENDING = 12'h000;
  localparam logic [11:0] INTC_OFS_MASK    = 12'h100;
  localparam logic [11:0] INTC_OFS_VECTOR  = 12'h200;
  localparam logic [11:0] INTC_OFS_ACK     = 12'h300;

  typedef enum logic {
    INTC_IDLE   = 1'b0,
    INTC_ACTIVE = 1'b1
  } intc_state_e;

endpackage

// File: rtl/intc_prio_sel.sv
// Combinational source selector.
// Scans the request vector starting at index 'start', wrapping from the top
// index back to 0, and returns the first set position.
//   req    request vector (pending & mask)
//   start  index where the scan begins
//   valid  at least one request is set
//   index  selected source index (0 when valid is low)
module intc_prio_sel
  import intc_pkg::*;
(
  input  logic [INTC_NUM_SRC-1:0] req,
  input  logic [INTC_ID_W-1:0]    start,
  output logic                    valid,
  output logic [INTC_ID_W-1:0]    index
);

  logic [INTC_ID_W-1:0] cand;

  // Walk offsets from farthest to nearest so the nearest hit to 'start'
  // overwrites the others. Modulo wrap comes free from the ID width because
  // the source count is a power of two.
  always_comb begin
    valid = 1'b0;
    index = '0;
    cand  = '0;
    for (int k = INTC_NUM_SRC - 1; k >= 0; k--) begin
      cand = start + INTC_ID_W'(k);
      if (req[cand]) begin
        valid = 1'b1;
        index = cand;
      end
    end
  end

endmodule

// File: rtl/intr_controller.sv
// Edge-triggered 8-source interrupt controller with a small register file.
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   CS_N, RD_N, WR_N   active-low chip select / read / write strobes
//   Addr, DataIn       register offset and write data
//   DataOut            combinational read data (0 when not reading)
//   SrcIntr_N          active-low interrupt lines (falling edge = request)
//   IrqN, IrqId        active-low CPU request and the signalled source index
// Registers: 0x000 Pending (W1C), 0x100 Mask, 0x200 Vector (RO), 0x300 Ack (WO).
// Build option: define INTC_ROUND_ROBIN_EN for round-robin arbitration that
// starts after the last acknowledged source; otherwise lowest index wins.
//
// state        | meaning
// -------------+--------------------------------------------------------
// INTC_IDLE    | no request outstanding, arbitrating over Pending & Mask
// INTC_ACTIVE  | IrqN low, IrqId held until Ack or W1C of that source
module intr_controller
  import intc_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    CS_N,
  input  logic                    RD_N,
  input  logic                    WR_N,
  input  logic [11:0]             Addr,
  input  logic [31:0]             DataIn,
  output logic [31:0]             DataOut,
  input  logic [INTC_NUM_SRC-1:0] SrcIntr_N,
  output logic                    IrqN,
  output logic [INTC_ID_W-1:0]    IrqId
);

  intc_state_e             state, state_nxt;
  logic [INTC_NUM_SRC-1:0] src_q;
  logic [INTC_NUM_SRC-1:0] pending, pending_nxt;
  logic [INTC_NUM_SRC-1:0] mask;
  logic [INTC_NUM_SRC-1:0] fall;
  logic [INTC_NUM_SRC-1:0] clr_vec;
  logic [INTC_NUM_SRC-1:0] wdata_lo;
  logic                    wr_en, rd_en;
  logic                    wr_pend, wr_mask, wr_ack;
  logic                    ack_hit, w1c_hit, active_done;
  logic                    latch_id;
  logic                    sel_valid;
  logic [INTC_ID_W-1:0]    sel_idx;
  logic [INTC_ID_W-1:0]    start_ptr;
  logic                    unused_data;

  assign wr_en    = ~CS_N & ~WR_N;
  assign rd_en    = ~CS_N & ~RD_N;
  assign wr_pend  = wr_en && (Addr == INTC_OFS_PENDING);
  assign wr_mask  = wr_en && (Addr == INTC_OFS_MASK);
  assign wr_ack   = wr_en && (Addr == INTC_OFS_ACK);
  assign wdata_lo = DataIn[INTC_NUM_SRC-1:0];

  assign unused_data = ^DataIn[31:INTC_NUM_SRC];

  // Falling edge: previous sample high, current line low.
  assign fall = src_q & ~SrcIntr_N;

  assign ack_hit     = (state == INTC_ACTIVE) && wr_ack &&
                       (DataIn[INTC_ID_W-1:0] == IrqId);
  assign w1c_hit     = (state == INTC_ACTIVE) && wr_pend && wdata_lo[IrqId];
  assign active_done = ack_hit | w1c_hit;

  always_comb begin
    clr_vec = '0;
    if (wr_pend) clr_vec = clr_vec | wdata_lo;
    if (ack_hit) clr_vec = clr_vec | (INTC_NUM_SRC'(1) << IrqId);
    // A new edge wins over a clear in the same cycle.
    pending_nxt = (pending & ~clr_vec) | fall;
  end

`ifdef INTC_ROUND_ROBIN_EN
  logic [INTC_ID_W-1:0] rr_ptr;

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (active_done) begin
      rr_ptr <= IrqId + INTC_ID_W'(1);
    end
  end

  assign start_ptr = rr_ptr;
`else
  assign start_ptr = '0;
`endif

  intc_prio_sel u_prio_sel (
    .req   (pending & mask),
    .start (start_ptr),
    .valid (sel_valid),
    .index (sel_idx)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      src_q   <= '1;
      pending <= '0;
      mask    <= '0;
      state   <= INTC_IDLE;
      IrqId   <= '0;
    end else begin
      src_q   <= SrcIntr_N;
      pending <= pending_nxt;
      state   <= state_nxt;
      if (wr_mask) mask <= wdata_lo;
      if (latch_id) IrqId <= sel_idx;
    end
  end

  always_comb begin
    state_nxt = state;
    latch_id  = 1'b0;
    case (state)
      INTC_IDLE: begin
        if (sel_valid) begin
          state_nxt = INTC_ACTIVE;
          latch_id  = 1'b1;
        end
      end
      INTC_ACTIVE: begin
        // Mask changes do not retract an outstanding request.
        if (active_done) state_nxt = INTC_IDLE;
      end
      default: state_nxt = INTC_IDLE;
    endcase
  end

  assign IrqN = (state != INTC_ACTIVE);

  always_comb begin
    DataOut = '0;
    if (rd_en) begin
      case (Addr)
        INTC_OFS_PENDING: DataOut = {{(32-INTC_NUM_SRC){1'b0}}, pending};
        INTC_OFS_MASK:    DataOut = {{(32-INTC_NUM_SRC){1'b0}}, mask};
        INTC_OFS_VECTOR:  DataOut = {(state == INTC_ACTIVE),
                                     {(31-INTC_ID_W){1'b0}}, IrqId};
        default:          DataOut = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_intr_controller.sv
module tb_intr_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        CS_N, RD_N, WR_N;
  logic [11:0] Addr;
  logic [31:0] DataIn;
  logic [31:0] DataOut;
  logic [7:0]  SrcIntr_N;
  logic        IrqN;
  logic [2:0]  IrqId;

  intr_controller dut (
    .clk       (clk),
    .reset     (reset),
    .CS_N      (CS_N),
    .RD_N      (RD_N),
    .WR_N      (WR_N),
    .Addr      (Addr),
    .DataIn    (DataIn),
    .DataOut   (DataOut),
    .SrcIntr_N (SrcIntr_N),
    .IrqN      (IrqN),
    .IrqId     (IrqId)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_item_t;

  sb_item_t sb_q[$];
  int n_checks = 0;
  int n_pass   = 0;

`ifdef INTC_ROUND_ROBIN_EN
  localparam logic [2:0] RR_FIRST  = 3'd7;
  localparam logic [2:0] RR_SECOND = 3'd0;
`else
  localparam logic [2:0] RR_FIRST  = 3'd0;
  localparam logic [2:0] RR_SECOND = 3'd7;
`endif

  task automatic check_val(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic sb_expect(input string tag, input logic [31:0] exp);
    sb_item_t it;
    it.tag = tag;
    it.exp = exp;
    sb_q.push_back(it);
  endtask

  task automatic sb_observe(input logic [31:0] obs);
    sb_item_t it;
    if (sb_q.size() == 0) begin
      check_val("sb_empty", 32'(sb_q.size()), 32'd1);
    end else begin
      it = sb_q.pop_front();
      check_val(it.tag, obs, it.exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    CS_N = 1'b0; WR_N = 1'b0; Addr = a; DataIn = d;
    step();
    CS_N = 1'b1; WR_N = 1'b1; DataIn = '0;
  endtask

  task automatic rd_exp(input string tag, input logic [11:0] a,
                        input logic [31:0] exp);
    sb_expect(tag, exp);
    CS_N = 1'b0; RD_N = 1'b0; Addr = a;
    #1;
    sb_observe(DataOut);
    CS_N = 1'b1; RD_N = 1'b1;
  endtask

  task automatic irq_exp(input string tag, input logic n, input logic [2:0] id);
    sb_expect({tag, "_irqn"}, {31'b0, n});
    sb_observe({31'b0, IrqN});
    if (!n) begin
      sb_expect({tag, "_irqid"}, {29'b0, id});
      sb_observe({29'b0, IrqId});
    end
  endtask

  // Pulse a set of lines low for one cycle to create edges.
  task automatic pulse(input logic [7:0] low_bits);
    SrcIntr_N = ~low_bits;
    step();
    SrcIntr_N = 8'hFF;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; CS_N = 1'b1; RD_N = 1'b1; WR_N = 1'b1;
    Addr = '0; DataIn = '0; SrcIntr_N = 8'hFF;
    step(); step();
    reset = 1'b0;

    // Reset state
    irq_exp("rst", 1'b1, 3'd0);
    check_val("rst_irqid", {29'b0, IrqId}, 32'd0);
    rd_exp("rst_pend", 12'h000, 32'h0);
    rd_exp("rst_mask", 12'h100, 32'h0);
    rd_exp("rst_vec",  12'h200, 32'h0);

    // Single source, one-cycle latency, level does not re-set
    wr(12'h100, 32'h01);
    SrcIntr_N = 8'hFE;
    step();
    rd_exp("t1_pend", 12'h000, 32'h01);
    irq_exp("t1", 1'b1, 3'd0);
    step();
    irq_exp("t2", 1'b0, 3'd0);
    rd_exp("t2_vec", 12'h200, 32'h8000_0000);
    rd_exp("ack_reads0", 12'h300, 32'h0);
    rd_exp("unmapped0", 12'h400, 32'h0);
    sb_expect("rdn_high0", 32'h0);
    CS_N = 1'b0; RD_N = 1'b1; Addr = 12'h100; #1;
    sb_observe(DataOut);
    CS_N = 1'b1;
    wr(12'h300, 32'h0);
    irq_exp("ack0", 1'b1, 3'd0);
    step();
    rd_exp("level_noset", 12'h000, 32'h0);
    irq_exp("level_idle", 1'b1, 3'd0);
    SrcIntr_N = 8'hFF;
    step();

    // Fixed priority, mismatched ack, matching ack, W1C end
    wr(12'h100, 32'hFF);
    pulse(8'h24);
    rd_exp("p24", 12'h000, 32'h24);
    step();
    irq_exp("sel2", 1'b0, 3'd2);
    wr(12'h300, 32'h3);
    irq_exp("badack", 1'b0, 3'd2);
    rd_exp("badack_pend", 12'h000, 32'h24);
    wr(12'h300, 32'h2);
    irq_exp("ack2_gap", 1'b1, 3'd0);
    check_val("idle_hold_id", {29'b0, IrqId}, 32'd2);
    rd_exp("ack2_pend", 12'h000, 32'h20);
    step();
    irq_exp("sel5", 1'b0, 3'd5);
    wr(12'h000, 32'h20);
    irq_exp("w1c5", 1'b1, 3'd0);
    rd_exp("w1c5_pend", 12'h000, 32'h0);

    // Edge on the acknowledged source in the same cycle as the ack
    pulse(8'h04);
    step();
    irq_exp("pre_coll", 1'b0, 3'd2);
    SrcIntr_N = 8'hFB;
    wr(12'h300, 32'h2);
    irq_exp("coll_gap", 1'b1, 3'd0);
    rd_exp("coll_pend", 12'h000, 32'h04);
    step();
    irq_exp("coll_re", 1'b0, 3'd2);
    wr(12'h000, 32'h04);
    SrcIntr_N = 8'hFF;
    irq_exp("coll_clr", 1'b1, 3'd0);

    // Mask removal does not retract an active request
    pulse(8'h08);
    step();
    irq_exp("sel3", 1'b0, 3'd3);
    wr(12'h100, 32'h00);
    irq_exp("mask_off", 1'b0, 3'd3);
    wr(12'h000, 32'h08);
    irq_exp("w1c3", 1'b1, 3'd0);
    step();
    irq_exp("masked_idle", 1'b1, 3'd0);

    // Reset while active
    wr(12'h100, 32'hFF);
    pulse(8'h02);
    step();
    irq_exp("sel1", 1'b0, 3'd1);
    reset = 1'b1;
    step();
    irq_exp("rst_act", 1'b1, 3'd0);
    rd_exp("rst_act_pend", 12'h000, 32'h0);
    rd_exp("rst_act_mask", 12'h100, 32'h0);
    reset = 1'b0;
    step();

    // Arbitration order for 0x81 after acknowledging source 0
    wr(12'h100, 32'hFF);
    pulse(8'h01);
    step();
    irq_exp("pre0", 1'b0, 3'd0);
    wr(12'h300, 32'h0);
    pulse(8'h81);
    rd_exp("p81", 12'h000, 32'h81);
    step();
    irq_exp("arb_first", 1'b0, RR_FIRST);
    wr(12'h300, {29'b0, RR_FIRST});
    irq_exp("arb_gap", 1'b1, 3'd0);
    step();
    irq_exp("arb_second", 1'b0, RR_SECOND);
    wr(12'h300, {29'b0, RR_SECOND});
    irq_exp("arb_done", 1'b1, 3'd0);
    rd_exp("arb_pend", 12'h000, 32'h0);

    check_val("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
